mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single byte-lane data memory port (mem_addr, mem_data_in[0:3], mem_data_out[0:3], mem_write_en) between two requesters in mips_core: instruction fetch (IF) and load/store (DM).
- Sequences each access through a fixed memory latency.
- Data requests have priority over fetch; a starvation guard bounds how long fetch can be blocked.
- Sits between mips_core's fetch/memory stages and the memory instance.

Parameters:
- MEM_LATENCY, 1, cycles the memory needs from a stable address to valid read data or a committed write (must be ≥1).
- STARVE_LIMIT, 3, consecutive IF losses after which IF wins the next conflict (must be ≥1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch byte address; stable while if_req is high
- if_rdata  out  8x[0:3]  fetched word bytes; valid only while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  load/store request; held high until dm_ready
- dm_we  in  1  1=store, 0=load; stable while dm_req is high
- dm_addr  in  32  data byte address
- dm_wdata  in  8x[0:3]  store bytes
- dm_rdata  out  8x[0:3]  load bytes; valid only while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for load/store
- mem_addr  out  32  memory address
- mem_data_in  out  8x[0:3]  memory write bytes
- mem_data_out  in  8x[0:3]  memory read bytes
- mem_write_en  out  1  memory write strobe
- busy  out  1  high in ACCESS and RESP states

Behaviour:
- Reset: rst_b=0 at a rising edge forces state=IDLE, latency counter=0, starve counter=0.
- Reset also drives all outputs to 0: both ready pulses, both rdata buses, mem_addr, mem_data_in, mem_write_en, busy.
- Reset mid-access aborts the access: no ready pulse is produced, and mem_write_en is 0 from the next cycle.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If one request is high, grant it.
  - If both are high, grant DM unless starve_cnt==STARVE_LIMIT, in which case grant IF.
  - On grant: register owner, address, we (IF is always read) and wdata; load latency counter with MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - mem_addr and mem_data_in are driven from the registered values, stable for all MEM_LATENCY cycles.
  - mem_write_en=1 only in the first ACCESS cycle, and only for a DM store.
  - Counter decrements each cycle. When it is 0, mem_data_out is captured into the owner's rdata register and the state moves to RESP.
- RESP:
  - The owner's ready is 1 for exactly one cycle, with rdata valid (stores return the prior captured value; requesters ignore it).
  - The non-owner's ready stays 0.
  - Next state is IDLE, unconditionally.
- Latency and throughput:
  - Ready is asserted MEM_LATENCY+1 cycles after the grant cycle.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
  - A request kept high, or re-raised, in the cycle after ready is sampled fresh in IDLE.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments when both requests are high in IDLE and DM is granted.
  - Clears whenever IF is granted.
  - Unchanged otherwise.
- Requests arriving during ACCESS or RESP are not sampled until IDLE.
- Request withdrawn mid-access (protocol violation): the access still completes and the ready pulse still fires; no error is flagged.
- Address wrap: addresses pass through unchanged. No alignment check; the core is responsible for word alignment.
- mem_addr holds its last value in IDLE; this is not required to be 0 after the first access.

Decomposition:
- Package mips_mem_pkg:
  - word_bytes_t (8-bit x4 byte array)
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - owner_t enum {OWN_IF, OWN_DM}
  - MEM_LATENCY_DEFAULT constant
- One sub-module, mem_arb_prio: combinational winner selection plus the saturating starvation counter.
- State machine, latency counter and datapath registers stay in mem_port_arbiter.

Test Plan:
- Single load, MEM_LATENCY=2: dm_req=1, dm_we=0, dm_addr=0x40, memory word {0x11,0x22,0x33,0x44} → mem_addr=0x40 for 2 cycles, mem_write_en never set, dm_ready pulses exactly 3 cycles after grant, dm_rdata={0x11,0x22,0x33,0x44}.
- Store: dm_we=1, dm_addr=0x80, wdata={0xDE,0xAD,0xBE,0xEF} → mem_write_en high exactly 1 cycle with mem_data_in equal to wdata, dm_ready 1 cycle later than the write + MEM_LATENCY-1, and a following load of 0x80 returns the same bytes.
- Conflict: if_req and dm_req both high from the same cycle, dm_req re-raised immediately after each dm_ready, STARVE_LIMIT=3 → first 3 grants go to DM, 4th to IF, then the counter restarts.
- Fetch only: if_req=1, if_addr=0x0, 0x4, 0x8 sequentially with MEM_LATENCY=1 → if_ready every 3 cycles, correct rdata each time, dm_ready never asserts.
- Reset mid-store: rst_b=0 in the first ACCESS cycle of a store → no dm_ready, all outputs 0 next cycle, state IDLE; a fresh request after rst_b=1 completes normally.
- Idle: no requests for 20 cycles → busy=0, both ready pulses=0, mem_write_en=0 throughout.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the mips_core memory-port arbiter.
// word_bytes_t index 0 is the byte at the lowest address of the word.
package mips_mem_pkg;

  typedef logic [0:3][7:0] word_bytes_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_LATENCY_DEFAULT  = 1;
  localparam int STARVE_LIMIT_DEFAULT = 3;

  // Bits needed to hold any value 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and load/store, with a saturating
// starvation counter that hands the next conflict to fetch.
module mem_arb_prio
  import mips_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_b,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   arb_en,
  output logic   grant_valid,
  output owner_t grant_owner
);

  localparam int SW = cnt_width(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  always_comb begin
    starved     = (starve_cnt == SW'(STARVE_LIMIT));
    grant_valid = arb_en && (if_req || dm_req);
    grant_owner = OWN_DM;
    if (if_req && (!dm_req || starved)) begin
      grant_owner = OWN_IF;
    end
  end

  // Only a lost conflict counts; any fetch grant restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (grant_owner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-lane data memory port between instruction fetch and
// load/store, sequencing each access through a fixed memory latency.
//
// state  | meaning
// IDLE   | sample requests, grant a winner and register its access
// ACCESS | address/data held to memory; latency counter runs down to 0
// RESP   | owner's ready pulses for one cycle with captured read data
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LATENCY  = MEM_LATENCY_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output word_bytes_t if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  word_bytes_t dm_wdata,
  output word_bytes_t dm_rdata,
  output logic        dm_ready,
  output logic [31:0] mem_addr,
  output word_bytes_t mem_data_in,
  input  word_bytes_t mem_data_out,
  output logic        mem_write_en,
  output logic        busy
);

  localparam int            LW       = cnt_width(MEM_LATENCY - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY - 1);

  arb_state_t    state_q, state_d;
  logic [LW-1:0] lat_q;
  owner_t        owner_q;
  logic          we_q;
  logic [31:0]   addr_q;
  word_bytes_t   wdata_q;
  word_bytes_t   if_rdata_q;
  word_bytes_t   dm_rdata_q;
  logic          grant_valid;
  owner_t        grant_owner;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst_b      (rst_b),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .arb_en     (state_q == IDLE),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_owner;
            lat_q   <= LAT_LOAD;
            if (grant_owner == OWN_DM) begin
              addr_q  <= dm_addr;
              we_q    <= dm_we;
              wdata_q <= dm_wdata;
            end else begin
              addr_q <= if_addr;
              we_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (lat_q == '0) begin
            if (owner_q == OWN_IF) begin
              if_rdata_q <= mem_data_out;
            end else begin
              dm_rdata_q <= mem_data_out;
            end
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    if_ready     = 1'b0;
    dm_ready     = 1'b0;
    mem_write_en = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        // Counter still at its load value only in the first ACCESS cycle.
        mem_write_en = we_q && (lat_q == LAT_LOAD);
        if (lat_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        busy     = 1'b1;
        if_ready = (owner_q == OWN_IF);
        dm_ready = (owner_q == OWN_DM);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;

endmodule
